// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises a shadow Fibonacci LFSR to the incoming
// bit stream, reports lock and counts prediction errors. Define LFSR_CHK_BITCNT_EN to add bit_count.
module lfsr_checker #(
    parameter int N           = 4,
    parameter int LOCK_THRESH = 8,
    parameter int WIN         = 16,
    parameter int LOSS_ERRS   = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_BITCNT_EN
    ,
    output logic [CNT_W-1:0] bit_count
`endif
);

    generate
        if (N < 2 || N > 8) begin : g_bad_width
            $fatal(1, "lfsr_checker: N must be in the range 2..8");
        end
    endgenerate

    localparam logic [7:0] TAP_MASK =
        (N == 2) ? 8'b0000_0011 :
        (N == 3) ? 8'b0000_0110 :
        (N == 4) ? 8'b0000_1100 :
        (N == 5) ? 8'b0001_0100 :
        (N == 6) ? 8'b0011_0000 :
        (N == 7) ? 8'b0110_0000 : 8'b1011_1000;
    localparam logic [N-1:0] TAPS = TAP_MASK[N-1:0];

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W   = $clog2(WIN + 1);
    localparam int EWIN_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_THRESH);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN - 1);
    localparam logic [EWIN_W-1:0]  EWIN_LOSS  = EWIN_W'(LOSS_ERRS);

    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

    state_t             state_reg;
    logic [N-1:0]       s_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic [MATCH_W-1:0] match_reg;
    logic [WIN_W-1:0]   win_reg;
    logic [EWIN_W-1:0]  ewin_reg;
    logic               locked_reg;
    logic               err_pulse_reg;
    logic [CNT_W-1:0]   err_count_reg;

    logic               accept;
    logic               predict;
    logic               mismatch;
    logic               lock_bit;
    logic               lock_err;
    logic [N-1:0]       shift_rx;
    logic [N-1:0]       shift_fw;
    logic [MATCH_W-1:0] match_inc;
    logic [EWIN_W-1:0]  ewin_inc;

    always_comb begin
        accept    = enable & bit_valid;
        predict   = ^(s_reg & TAPS);
        mismatch  = bit_in ^ predict;
        shift_rx  = {s_reg[N-2:0], bit_in};
        shift_fw  = {s_reg[N-2:0], predict};
        lock_bit  = accept && (state_reg == ST_LOCKED);
        lock_err  = lock_bit && mismatch;
        match_inc = match_reg + 1'b1;
        ewin_inc  = ewin_reg + EWIN_W'(mismatch);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_SEARCH;
            s_reg      <= '0;
            fill_reg   <= '0;
            match_reg  <= '0;
            win_reg    <= '0;
            ewin_reg   <= '0;
            locked_reg <= 1'b0;
        end else if (!enable) begin
            // s_reg is deliberately held so a brief disable does not discard history
            state_reg  <= ST_SEARCH;
            fill_reg   <= '0;
            match_reg  <= '0;
            win_reg    <= '0;
            ewin_reg   <= '0;
            locked_reg <= 1'b0;
        end else if (bit_valid) begin
            case (state_reg)
                ST_SEARCH: begin
                    s_reg <= shift_rx;
                    if (fill_reg == FILL_LAST) begin
                        state_reg <= ST_VERIFY;
                        fill_reg  <= '0;
                        match_reg <= '0;
                    end else begin
                        fill_reg <= fill_reg + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    // a mismatch re-seeds the shadow register from the received data
                    s_reg <= shift_rx;
                    if (s_reg == '0) begin
                        state_reg <= ST_SEARCH;
                        fill_reg  <= '0;
                        match_reg <= '0;
                    end else if (mismatch) begin
                        match_reg <= '0;
                    end else if (match_inc == MATCH_LOCK) begin
                        state_reg  <= ST_LOCKED;
                        locked_reg <= 1'b1;
                        match_reg  <= '0;
                        win_reg    <= '0;
                        ewin_reg   <= '0;
                    end else begin
                        match_reg <= match_inc;
                    end
                end
                ST_LOCKED: begin
                    // flywheel: the prediction, not the received bit, feeds the register
                    s_reg <= shift_fw;
                    if (ewin_inc == EWIN_LOSS) begin
                        state_reg  <= ST_SEARCH;
                        locked_reg <= 1'b0;
                        fill_reg   <= '0;
                        win_reg    <= '0;
                        ewin_reg   <= '0;
                    end else if (win_reg == WIN_LAST) begin
                        win_reg  <= '0;
                        ewin_reg <= '0;
                    end else begin
                        win_reg  <= win_reg + 1'b1;
                        ewin_reg <= ewin_inc;
                    end
                end
                default: begin
                    state_reg  <= ST_SEARCH;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            err_pulse_reg <= lock_err;
            if (clear_cnt) begin
                err_count_reg <= {{(CNT_W-1){1'b0}}, lock_err};
            end else if (lock_err && !(&err_count_reg)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end
        end
    end

`ifdef LFSR_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_count_reg <= '0;
        end else if (clear_cnt) begin
            bit_count_reg <= {{(CNT_W-1){1'b0}}, lock_bit};
        end else if (lock_bit && !(&bit_count_reg)) begin
            bit_count_reg <= bit_count_reg + 1'b1;
        end
    end

    assign bit_count = bit_count_reg;
`endif

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker (N=4 defaults): a bit-history reference model predicts
// every cycle's outputs; a monitor pops and compares them on the falling edge.
module tb_lfsr_checker;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             bit_valid;
    logic             bit_in;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
`ifdef LFSR_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_count;
`endif

    lfsr_checker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
`ifdef LFSR_CHK_BITCNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               en;
        bit               v;
        bit               b;
        bit               clr;
        bit               locked;
        bit               pulse;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] bits;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    int   fail_prints = 0;

    // generator output for seed 4'b0001, period 15
    int seq[15] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    int gen_idx = 0;
    bit saw_lock;

    // reference model: mode 0=search 1=verify 2=locked; hist[k] is the bit k steps back
    int m_mode;
    int m_hist[$];
    int m_fill, m_run, m_win, m_ewin, m_cnt, m_bits;
    bit m_pulse;

    task automatic model_reset();
        m_mode = 0;
        m_hist = '{0, 0, 0, 0};
        m_fill = 0; m_run = 0; m_win = 0; m_ewin = 0;
        m_cnt = 0; m_bits = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit v, input bit b, input bit clr);
        int p;
        bit err;
        bit in_lock;
        err = 1'b0;
        in_lock = 1'b0;
        if (!en) begin
            m_mode = 0; m_fill = 0; m_run = 0; m_win = 0; m_ewin = 0;
        end else if (v) begin
            // sequence recurrence x[n] = x[n-4] xor x[n-3]
            p = m_hist[3] ^ m_hist[2];
            if (m_mode == 0) begin
                m_hist.push_front(int'(b));
                m_fill++;
                if (m_fill == 4) begin m_mode = 1; m_fill = 0; m_run = 0; end
            end else if (m_mode == 1) begin
                if (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3] == 0) begin
                    m_mode = 0; m_fill = 0; m_run = 0;
                end else begin
                    m_run = (int'(b) == p) ? m_run + 1 : 0;
                    if (m_run == 8) begin m_mode = 2; m_run = 0; m_win = 0; m_ewin = 0; end
                end
                m_hist.push_front(int'(b));
            end else begin
                in_lock = 1'b1;
                err = (int'(b) != p);
                m_hist.push_front(p);
                m_ewin += int'(err);
                m_win++;
                if (m_ewin == 4) begin
                    m_mode = 0; m_fill = 0; m_win = 0; m_ewin = 0;
                end else if (m_win == 16) begin
                    m_win = 0; m_ewin = 0;
                end
            end
            if (m_hist.size() > 4) void'(m_hist.pop_back());
        end
        m_pulse = err;
        if (clr) m_cnt = err ? 1 : 0;
        else if (err && m_cnt < 65535) m_cnt++;
        if (clr) m_bits = in_lock ? 1 : 0;
        else if (in_lock && m_bits < 65535) m_bits++;
    endtask

    task automatic send(input bit en, input bit v, input bit b, input bit clr);
        exp_t e;
        enable = en; bit_valid = v; bit_in = b; clear_cnt = clr;
        @(posedge clk);
        model_step(en, v, b, clr);
        e.en = en; e.v = v; e.b = b; e.clr = clr;
        e.locked = (m_mode == 2);
        e.pulse  = m_pulse;
        e.cnt    = CNT_W'(m_cnt);
        e.bits   = CNT_W'(m_bits);
        sb_q.push_back(e);
        #1;
    endtask

    // accept the next generator bit, optionally inverted
    task automatic acc(input bit flip);
        bit b;
        b = 1'(seq[gen_idx]) ^ flip;
        gen_idx = (gen_idx + 1) % 15;
        send(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic lock12(input string tag, input bit gaps);
        for (int i = 1; i <= 12; i++) begin
            if (gaps) send(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            acc(1'b0);
            if (i == 11) check({tag, " not locked after 11"}, int'(locked), 0);
        end
        check({tag, " locked after 12"}, int'(locked), 1);
    endtask

    task automatic adv_to(input int k);
        acc(1'b0);
        for (int i = 0; i < 16 && m_win != k; i++) acc(1'b0);
    endtask

    task automatic monitor();
        exp_t e;
        bit bad;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                txn++;
                $display("txn %0d: en=%0b valid=%0b bit=%0b clr=%0b -> locked=%0b pulse=%0b err_count=%0d",
                         txn, e.en, e.v, e.b, e.clr, locked, err_pulse, err_count);
                bad = (locked !== e.locked) || (err_pulse !== e.pulse) || (err_count !== e.cnt);
`ifdef LFSR_CHK_BITCNT_EN
                bad = bad || (bit_count !== e.bits);
`endif
                if (bad) begin
                    errors++;
                    if (fail_prints < 20)
                        $display("FAIL scoreboard txn %0d: got locked=%0b pulse=%0b cnt=%0d, expected locked=%0b pulse=%0b cnt=%0d",
                                 txn, locked, err_pulse, err_count, e.locked, e.pulse, e.cnt);
                    fail_prints++;
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;
        model_reset();
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("reset locked", int'(locked), 0);
        check("reset err_pulse", int'(err_pulse), 0);
        check("reset err_count", int'(err_count), 0);
        reset_n = 1'b1;

        // clean lock from the seeded generator, then 100 bits total without error
        lock12("clean", 1'b0);
        repeat (88) acc(1'b0);
        check("clean err_count", int'(err_count), 0);
        check("clean still locked", int'(locked), 1);

        // single inverted bit: one pulse, flywheel absorbs it
        acc(1'b1);
        check("single err_pulse", int'(err_pulse), 1);
        check("single err_count", int'(err_count), 1);
        acc(1'b0);
        check("single pulse drops", int'(err_pulse), 0);
        check("single stays locked", int'(locked), 1);
        repeat (20) acc(1'b0);
        check("single no propagation", int'(err_count), 1);

        // 3 errors at window end plus 1 at next window start: window reset keeps lock
        adv_to(13);
        repeat (4) acc(1'b1);
        check("split window keeps lock", int'(locked), 1);
        check("split window err_count", int'(err_count), 5);
        repeat (4) acc(1'b0);

        // 4 errors ending on the last bit of a window force loss
        send(1'b1, 1'b0, 1'b0, 1'b1);
        check("clear_cnt", int'(err_count), 0);
        adv_to(0);
        adv_to(12);
        repeat (3) acc(1'b1);
        check("3 errors keep lock", int'(locked), 1);
        acc(1'b1);
        check("loss at window end", int'(locked), 0);
        check("loss err_count", int'(err_count), 4);
        lock12("relock", 1'b0);

        // 4 errors at the start of a window
        adv_to(0);
        repeat (4) acc(1'b1);
        check("loss at window start", int'(locked), 0);
        check("loss2 err_count", int'(err_count), 8);

        // stuck-at-zero line never locks and never counts
        send(1'b0, 1'b0, 1'b0, 1'b0);
        saw_lock = 1'b0;
        for (int i = 0; i < 64; i++) begin
            send(1'b1, 1'b1, 1'b0, 1'b0);
            if (locked) saw_lock = 1'b1;
        end
        check("stuck-at-zero never locks", int'(saw_lock), 0);
        check("stuck-at-zero err_count", int'(err_count), 8);

        // gaps in bit_valid, enable drop, clear with simultaneous error
        send(1'b0, 1'b0, 1'b0, 1'b1);
        lock12("gapped", 1'b1);
        acc(1'b1);
        check("gapped err_count", int'(err_count), 1);
        send(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        check("enable drop unlocks", int'(locked), 0);
        check("enable drop holds count", int'(err_count), 1);
        lock12("after enable", 1'b0);
        send(1'b1, 1'b1, 1'(seq[gen_idx]) ^ 1'b1, 1'b1);
        gen_idx = (gen_idx + 1) % 15;
        check("clear with error count", int'(err_count), 1);
        check("clear with error pulse", int'(err_pulse), 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit en, v, b, c;
            en = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 49) == 0);
            if (en && v) begin
                b = 1'(seq[gen_idx]) ^ ($urandom_range(0, 24) == 0);
                gen_idx = (gen_idx + 1) % 15;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            send(en, v, b, c);
        end

        // asynchronous reset while locked with err_count=3
        send(1'b0, 1'b0, 1'b0, 1'b1);
        lock12("pre-reset", 1'b0);
        acc(1'b1);
        repeat (5) acc(1'b0);
        acc(1'b1);
        repeat (5) acc(1'b0);
        acc(1'b1);
        check("pre-reset err_count", int'(err_count), 3);
        #5;
        reset_n = 1'b0;
        #1;
        check("async reset locked", int'(locked), 0);
        check("async reset err_pulse", int'(err_pulse), 0);
        check("async reset err_count", int'(err_count), 0);
`ifdef LFSR_CHK_BITCNT_EN
        check("async reset bit_count", int'(bit_count), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        lock12("post-reset", 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side PRBS checker for the serial bit stream produced by the team's Fibonacci LFSR generator. The block self-synchronises a shadow LFSR to the incoming bits, declares lock, and then predicts every following bit. It counts mismatches and drops lock when the error density is too high. It sits at the far end of a link or loopback path under test and reports lock status and an error count to the test controller.

Parameters:
N, 4, LFSR width; legal range 2..8; any other value is a fatal elaboration error.
LOCK_THRESH, 8, consecutive correct predictions in VERIFY needed to enter LOCKED.
WIN, 16, window length in accepted bits used for loss-of-lock detection.
LOSS_ERRS, 4, errors within one window that force loss of lock.
CNT_W, 16, width of the error counter.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  checker run; low forces SEARCH and clears the fill count
bit_valid  in  1  bit_in is meaningful this cycle
bit_in  in  1  received serial bit, one per valid cycle
clear_cnt  in  1  synchronous clear of err_count
locked  out  1  registered; high while in LOCKED
err_pulse  out  1  registered; one-cycle pulse per mismatching bit in LOCKED
err_count  out  CNT_W  registered saturating count of errors seen in LOCKED

Behaviour:
- Feedback function f(s) over the shadow register s[N-1:0]:
  - N=2: s1^s0
  - N=3: s2^s1
  - N=4: s3^s2
  - N=5: s4^s2
  - N=6: s5^s4
  - N=7: s6^s5
  - N=8: s7^s5^s4^s3
- Stream convention: the generator shifts left and emits its new LSB each cycle, so the expected next bit is f(s).
- Reset (asynchronous, reset_n low): s=0, state=SEARCH, fill/match/window counters=0, locked=0, err_pulse=0, err_count=0.
- All state changes occur only on cycles where enable=1 and bit_valid=1 (an "accepted bit"), except enable, clear_cnt and reset.
- SEARCH:
  - s <= {s[N-2:0], bit_in}; fill++.
  - After N accepted bits, go to VERIFY with match=0.
- VERIFY:
  - Compare bit_in with f(s). Match: match++. Mismatch: match=0.
  - In both cases s <= {s[N-2:0], bit_in}, so a mismatch re-seeds the register from received data.
  - When match reaches LOCK_THRESH, go to LOCKED; locked rises on the cycle after that accepted bit.
  - If s==0 (lock-up state), go to SEARCH with fill=0. A stuck-at-0 line must never lock.
- LOCKED (flywheel):
  - s <= {s[N-2:0], f(s)}; the prediction is used, never bit_in, so errors do not propagate.
  - A mismatch produces err_pulse=1 on the next cycle and err_count++ (saturating at all-ones).
  - win counts accepted bits 0..WIN-1 and ewin counts errors in the current window.
  - If ewin reaches LOSS_ERRS, go to SEARCH next cycle (fill=0, locked=0). This check includes an error on the last bit of a window.
  - At the end of a window, win=0 and ewin=0.
- Error rule: errors in SEARCH/VERIFY never increment err_count or pulse err_pulse.
- enable=0: state forced to SEARCH, fill/match/window counters cleared, s held, locked=0 next cycle, err_count held.
- clear_cnt: err_count=0 next cycle. If clear_cnt and an error occur in the same cycle, the result is err_count=1.
- Latency: err_pulse and err_count update one cycle after the offending accepted bit.
- Minimum bits to lock: N+LOCK_THRESH (12 with defaults).

Optional Feature:
- Macro LFSR_CHK_BITCNT_EN.
- When defined:
  - Adds output bit_count (CNT_W bits, registered).
  - bit_count counts accepted bits while in LOCKED and saturates at all-ones.
  - clear_cnt clears bit_count together with err_count, so software can compute BER = err_count/bit_count.
  - bit_count resets to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Clean lock: N=4, drive continuous period-15 stream 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 (generator seeded 4'b0001) -> locked=1 exactly one cycle after 12th accepted bit; err_count stays 0 for 100 bits.
- Single error: after lock, invert one bit -> err_pulse high exactly one cycle, err_count=1, locked stays 1, next bits produce no further errors (flywheel).
- Loss of lock: after lock, invert 4 bits within 16 accepted bits -> locked=0 on cycle after 4th error, err_count=4; then clean stream -> relock after 12 further bits.
- Stuck-at-zero: drive bit_in=0 for 64 accepted bits -> locked never asserts, err_count=0.
- Gaps and enable: clean stream with bit_valid low on alternate cycles -> lock after 12 accepted bits; drop enable one cycle -> locked=0, err_count held; clear_cnt with simultaneous error -> err_count=1.
- Reset mid-run: assert reset_n low while locked and err_count=3 -> locked, err_pulse, err_count all 0 immediately (asynchronous); with LFSR_CHK_BITCNT_EN, bit_count=0.
